load_data_align: RTL and testbench
==================================

// Module: load_data_align
// PURPOSE
//  Read-side counterpart of store write-enable alignment in the EXM/WB path. Issues word-aligned
//  read addresses to the synchronous data BRAM and extracts the byte/half/word selected by
//  addr[1:0]. Sign- or zero-extends the result per funct3.
//  Loads that cross a word boundary (LH/LHU off=3, LW off!=0) are split into two BRAM reads and merged.
// PARAMETERS
//  AWIDTH   32  address width; mem_addr is AWIDTH bits, bits[1:0] always 0
//  DWIDTH   32  data width; fixed 32 (RV32), kept only for port sizing
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   synchronous reset, active-high
//  req_valid  in   1   load request this cycle; accepted only when !busy && !stall
//  req_funct3 in   3   RV32I load funct3: LB=0 LH=1 LW=2 LBU=4 LHU=5
//  req_addr   in   32  byte address of load
//  stall      in   1   pipeline freeze; holds every register, state and mem_addr
//  busy       out  1   high while a split load is in flight (state!=IDLE); core must stall fetch/decode
//  mem_en     out  1   BRAM read enable = !stall; BRAM output holds while stalled
//  mem_addr   out  32  word-aligned BRAM read address (combinational from state/req)
//  mem_rdata  in   32  BRAM read data, valid 1 cycle after mem_addr/mem_en
//  rsp_valid  out  1   registered: rsp_data holds a completed load
//  rsp_data   out  32  registered aligned, extended load result
//  rsp_err    out  1   registered: funct3 illegal (3,6,7); rsp_data=0 in that case
// BEHAVIOUR
//  Reset: state=IDLE, s1_valid=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, lo_buf=0.
//  Stage 1 (issue): on accept, mem_addr={req_addr[31:2],2'b00}; register s1_valid, funct3, off=addr[1:0], word addr.
//  Stage 2 (return): next cycle, extract from mem_rdata using s1 regs; register rsp_* (latency 2).
//  Non-crossing loads are pipelined: one accepted per cycle, back-to-back rsp_valid.
//  rsp_valid pulses one cycle per load, 0 when no load completes (unless stall holds it).
//  Extraction: window = {hi,lo}>>(8*off); LB/LBU use [7:0], LH/LHU use [15:0], LW [31:0];
//  LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend. Non-split: hi=don't care.
//  FSM IDLE/LO/HI for crossing loads:
//   IDLE: accept crossing req -> issue word A, go LO, busy=1.
//   LO: mem_rdata=word A -> lo_buf; mem_addr=A+4 (wraps modulo 2^32); go HI.
//   HI: mem_rdata=word A+4 is hi; register merged rsp; go IDLE. Crossing latency = 3 cycles.
//  busy=1 in LO and HI; req_valid ignored when busy=1 (caller holds request, no drop).
//  Stall: all state frozen incl. FSM, s1 regs, lo_buf, rsp_*; mem_en=0; no acceptance.
//  req_valid && stall same cycle: not accepted; request must persist.
//  Illegal funct3: treated as non-crossing, single read; rsp_valid=1, rsp_err=1, rsp_data=0.
//  Reset mid-split (LO/HI): abandon load, no rsp_valid, return to IDLE next cycle.
// STRUCTURE
//  Shared package (load_pkg): funct3 constants LB/LH/LW/LBU/LHU, FSM state encoding,
//  crossing predicate (size, off) as constant function.
//  Sub-module load_extend (combinational): {hi,lo}, off, funct3 -> data, err.
//  Top: FSM, stage-1 regs, lo_buf, output regs, mem_addr mux.
// TESTING
//  BRAM model: word[0x100]=0x8877_6655, word[0x104]=0xDDCC_BBAA, 1-cycle read latency.
//  LB 0x103 -> rsp 0xFFFF_FF88; LBU 0x103 -> 0x0000_0088; LH 0x102 -> 0xFFFF_8877;
//  LHU 0x101 -> 0x0000_7766; all 2-cycle latency.
//  LW 0x100,0x101..back-to-back LB 0x100..0x103 each cycle -> 4 consecutive rsp_valid, 0x55,0x66,0x77,0xFFFFFF88.
//  LW 0x102 -> busy 2 cycles, mem_addr 0x100 then 0x104, rsp 0xBBAA_8877 at +3 cycles.
//  LH 0x103 -> rsp 0xFFFF_AA88.
//  Stall 3 cycles in LO during LW 0x101: no state change, mem_en=0, final rsp 0xAA88_7766 unchanged.
//  rst during HI -> no rsp_valid, busy=0 next cycle.
//  funct3=3 @0x100 -> rsp_err=1, rsp_data=0.
//  LW at 0xFFFF_FFFE -> second read mem_addr=0x0000_0000 (wrap).

Source files
------------

// File: rtl/load_data_align_pkg.sv
// Shared definitions for the load alignment path.
//   - RV32I load funct3 codes
//   - FSM state encoding for word-crossing (split) loads
//   - is_crossing(): true when a load of the given size at byte offset
//     off would straddle two BRAM words and needs two reads
package load_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    // Illegal funct3 codes are never crossing: they take the single-read path.
    function automatic logic is_crossing(input logic [2:0] funct3, input logic [1:0] off);
        logic crossing;
        crossing = 1'b0;
        case (funct3)
            F3_LH, F3_LHU: crossing = (off == 2'd3);
            F3_LW:         crossing = (off != 2'd0);
            default:       crossing = 1'b0;
        endcase
        return crossing;
    endfunction

endpackage

// File: rtl/load_data_align_extend.sv
// Combinational extractor: picks the byte/half/word starting at byte
// offset off out of the 64-bit window {hi, lo} and sign/zero-extends it.
// Ports:
//   hi, lo  : upper/lower memory words (hi only matters for split loads)
//   off     : byte offset of the load within lo
//   funct3  : RV32I load funct3
//   data    : aligned, extended result (0 for illegal funct3)
//   err     : funct3 is not a legal load encoding
module load_extend
    import load_pkg::*;
(
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            err
);

    logic [XLEN-1:0] win;

    always_comb begin
        win  = XLEN'({hi, lo} >> {off, 3'b000});
        data = '0;
        err  = 1'b0;
        case (funct3)
            F3_LB:   data = {{24{win[7]}}, win[7:0]};
            F3_LBU:  data = {24'h0, win[7:0]};
            F3_LH:   data = {{16{win[15]}}, win[15:0]};
            F3_LHU:  data = {16'h0, win[15:0]};
            F3_LW:   data = win;
            default: err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_data_align.sv
// Load data alignment for the EXM/WB path. Issues word-aligned reads to a
// synchronous BRAM (1-cycle latency) and returns the aligned, extended load.
// Non-crossing loads are fully pipelined (latency 2); loads that straddle a
// word boundary are split into two reads through the IDLE/LO/HI FSM
// (latency 3, busy high for 2 cycles).
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/funct3/addr : load request, accepted when !busy && !stall
//   stall                 : freezes every register; suppresses BRAM reads
//   busy                  : split load in flight (state != IDLE)
//   mem_en, mem_addr      : BRAM read enable and word-aligned read address
//   mem_rdata             : BRAM read data, one cycle after mem_addr
//   rsp_valid/data/err    : registered load result
//
// Handshake: a request is taken on a rising edge where req_valid && !busy &&
// !stall; otherwise the caller must keep it asserted and unchanged.
module load_data_align
    import load_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [2:0]        req_funct3,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic              stall,
    output logic              busy,
    output logic              mem_en,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              rsp_err
);

    state_t            state;
    state_t            state_nx;
    logic              s1_valid;
    logic [2:0]        s1_funct3;
    logic [1:0]        s1_off;
    logic [AWIDTH-1:0] s1_waddr;
    logic [DWIDTH-1:0] lo_buf;

    logic              accept;
    logic              crossing;
    logic              rsp_load;
    logic [DWIDTH-1:0] ext_hi;
    logic [DWIDTH-1:0] ext_lo;
    logic [DWIDTH-1:0] ext_data;
    logic              ext_err;

    assign busy     = (state != ST_IDLE);
    assign mem_en   = !stall;
    assign accept   = req_valid && !busy && !stall;
    assign crossing = is_crossing(req_funct3, req_addr[1:0]);
    // A response is produced either by the pipelined path or the HI step.
    assign rsp_load = s1_valid || (state == ST_HI);

    // Read address: the request word while idle, the following word
    // (wrapping modulo 2^AWIDTH) during a split load.
    always_comb begin
        mem_addr = {req_addr[AWIDTH-1:2], 2'b00};
        if (state != ST_IDLE) begin
            mem_addr = s1_waddr + AWIDTH'(4);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept && crossing) state_nx = ST_LO;
            ST_LO:   state_nx = ST_HI;
            ST_HI:   state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // In HI the returning word is the upper half of the window; otherwise
    // the returning word is the only one needed and hi is a don't-care.
    always_comb begin
        ext_lo = mem_rdata;
        ext_hi = mem_rdata;
        if (state == ST_HI) begin
            ext_lo = lo_buf;
        end
    end

    load_extend u_extend (
        .hi     (ext_hi),
        .lo     (ext_lo),
        .off    (s1_off),
        .funct3 (s1_funct3),
        .data   (ext_data),
        .err    (ext_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            s1_valid  <= 1'b0;
            s1_funct3 <= '0;
            s1_off    <= '0;
            s1_waddr  <= '0;
            lo_buf    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (!stall) begin
            state    <= state_nx;
            s1_valid <= accept && !crossing;
            // The s1 fields double as the split-load context while busy.
            if (accept) begin
                s1_funct3 <= req_funct3;
                s1_off    <= req_addr[1:0];
                s1_waddr  <= {req_addr[AWIDTH-1:2], 2'b00};
            end
            if (state == ST_LO) begin
                lo_buf <= mem_rdata;
            end
            rsp_valid <= rsp_load;
            if (rsp_load) begin
                rsp_data <= ext_data;
                rsp_err  <= ext_err;
            end
        end
    end

endmodule

// File: tb/tb_load_data_align.sv
module tb_load_data_align;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic        stall;
    logic        busy;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int n_pass;
    int n_total;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[17];

    load_data_align #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .stall      (stall),
        .busy       (busy),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- BRAM model ----------------
    function automatic logic [31:0] bram_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h8877_6655;
            32'h0000_0104: return 32'hDDCC_BBAA;
            32'hFFFF_FFFC: return 32'h1234_5678;
            32'h0000_0000: return 32'h9ABC_DEF0;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) mem_rdata <= 32'h0;
        else if (mem_en) mem_rdata <= bram_word(mem_addr);
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic [2:0] f3, input logic [31:0] addr);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_addr   = addr;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Presents one request at a negedge, waits (bounded) for its response.
    task automatic run_vec(input int idx);
        int lat;
        vec_t v;
        v = vecs[idx];
        drive_req(v.f3, v.addr);
        lat = 0;
        @(posedge clk);
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            req_valid = 1'b0;
            if (rsp_valid) break;
        end
        if (!rsp_valid) lat = 99;
        check($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("vec%0d data", idx), rsp_data, v.exp_data);
        check($sformatf("vec%0d err", idx), 32'(rsp_err), 32'(v.exp_err));
    endtask

    // Split word load: checks both issued addresses, busy window and result.
    task automatic cross_seq(input string name, input logic [31:0] addr,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] exp_data);
        idle(2);
        drive_req(load_pkg::F3_LW, addr);
        #1;
        check({name, " addr0"}, mem_addr, a0);
        check({name, " busy0"}, 32'(busy), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check({name, " addr1"}, mem_addr, a1);
        check({name, " busy1"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({name, " busy2"}, 32'(busy), 32'd1);
        check({name, " rsp_valid early"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({name, " data"}, rsp_data, exp_data);
        check({name, " busy3"}, 32'(busy), 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0]  = '{3'd0, 32'h103, 32'hFFFF_FF88, 1'b0, 2};
        vecs[1]  = '{3'd4, 32'h103, 32'h0000_0088, 1'b0, 2};
        vecs[2]  = '{3'd1, 32'h102, 32'hFFFF_8877, 1'b0, 2};
        vecs[3]  = '{3'd5, 32'h101, 32'h0000_7766, 1'b0, 2};
        vecs[4]  = '{3'd2, 32'h100, 32'h8877_6655, 1'b0, 2};
        vecs[5]  = '{3'd0, 32'h101, 32'h0000_0066, 1'b0, 2};
        vecs[6]  = '{3'd1, 32'h100, 32'h0000_6655, 1'b0, 2};
        vecs[7]  = '{3'd5, 32'h102, 32'h0000_8877, 1'b0, 2};
        vecs[8]  = '{3'd1, 32'h103, 32'hFFFF_AA88, 1'b0, 3};
        vecs[9]  = '{3'd5, 32'h103, 32'h0000_AA88, 1'b0, 3};
        vecs[10] = '{3'd2, 32'h102, 32'hBBAA_8877, 1'b0, 3};
        vecs[11] = '{3'd2, 32'h101, 32'hAA88_7766, 1'b0, 3};
        vecs[12] = '{3'd2, 32'h103, 32'hCCBB_AA88, 1'b0, 3};
        vecs[13] = '{3'd3, 32'h100, 32'h0000_0000, 1'b1, 2};
        vecs[14] = '{3'd6, 32'h101, 32'h0000_0000, 1'b1, 2};
        vecs[15] = '{3'd7, 32'h103, 32'h0000_0000, 1'b1, 2};
        vecs[16] = '{3'd1, 32'h106, 32'hFFFF_DDCC, 1'b0, 2};

        n_pass     = 0;
        n_total    = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        stall      = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state (checked while reset is still asserted).
        check("reset busy", 32'(busy), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_data", rsp_data, 32'h0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset mem_en", 32'(mem_en), 32'd1);
        rst = 1'b0;
        idle(1);

        // Table-driven single loads.
        for (int i = 0; i < 17; i++) run_vec(i);

        // Back-to-back LB 0x100..0x103: four consecutive responses.
        idle(2);
        for (int i = 0; i < 7; i++) begin
            if (i >= 2 && i < 6) begin
                check($sformatf("b2b rsp_valid %0d", i - 2), 32'(rsp_valid), 32'd1);
                check($sformatf("b2b data %0d", i - 2), rsp_data, exp_q.pop_front());
            end else if (i == 6) begin
                check("b2b rsp_valid after", 32'(rsp_valid), 32'd0);
            end
            if (i < 4) begin
                drive_req(load_pkg::F3_LB, 32'h100 + 32'(i));
                case (i)
                    0: exp_q.push_back(32'h0000_0055);
                    1: exp_q.push_back(32'h0000_0066);
                    2: exp_q.push_back(32'h0000_0077);
                    default: exp_q.push_back(32'hFFFF_FF88);
                endcase
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Split loads: address sequence, busy window, wrap-around.
        cross_seq("lw102", 32'h102, 32'h100, 32'h104, 32'hBBAA_8877);
        cross_seq("wrap", 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000, 32'hDEF0_1234);

        // Request during stall is not accepted; it goes once stall drops.
        idle(2);
        drive_req(load_pkg::F3_LB, 32'h103);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stall idle busy", 32'(busy), 32'd0);
            check("stall idle rsp_valid", 32'(rsp_valid), 32'd0);
            check("stall idle mem_en", 32'(mem_en), 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("post-stall rsp early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("post-stall rsp_valid", 32'(rsp_valid), 32'd1);
        check("post-stall data", rsp_data, 32'hFFFF_FF88);
        stall = 1'b1;
        @(negedge clk);
        check("stall holds rsp_valid", 32'(rsp_valid), 32'd1);
        check("stall holds rsp_data", rsp_data, 32'hFFFF_FF88);
        stall = 1'b0;
        @(negedge clk);
        check("rsp_valid pulse ends", 32'(rsp_valid), 32'd0);

        // Stall 3 cycles in LO during LW 0x101.
        idle(2);
        drive_req(load_pkg::F3_LW, 32'h101);
        @(negedge clk);
        req_valid = 1'b0;
        check("lo busy", 32'(busy), 32'd1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("lo stall%0d busy", i), 32'(busy), 32'd1);
            check($sformatf("lo stall%0d mem_en", i), 32'(mem_en), 32'd0);
            check($sformatf("lo stall%0d mem_addr", i), mem_addr, 32'h104);
            check($sformatf("lo stall%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        check("hi after stall busy", 32'(busy), 32'd1);
        check("hi after stall rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("stalled split rsp_valid", 32'(rsp_valid), 32'd1);
        check("stalled split data", rsp_data, 32'hAA88_7766);
        check("stalled split busy", 32'(busy), 32'd0);

        // Reset during HI abandons the load.
        idle(2);
        drive_req(load_pkg::F3_LW, 32'h102);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre-reset busy (HI)", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("reset-in-HI busy", 32'(busy), 32'd0);
        check("reset-in-HI rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("after reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("after reset busy", 32'(busy), 32'd0);

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
